// File: rtl/mem2p_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem2p_arb_pkg;

  localparam int unsigned RSP_FIFO_DEPTH = 2;
  localparam int unsigned RR_PTR_W       = 3;
  localparam int unsigned RSP_ID_W       = 3;
  // Widest supported memory data width; narrower instances leave the top bits at zero.
  localparam int unsigned RSP_DATA_W     = 64;

  typedef logic [RR_PTR_W-1:0] rr_ptr_t;

  typedef struct packed {
    logic [RSP_ID_W-1:0]   id;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer, then masks by en.
// A masked pick blocks the cycle so that requester keeps its priority slot.
module rr_arbiter
  import mem2p_arb_pkg::*;
#(
  parameter int unsigned G_NREQ = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [G_NREQ-1:0] req,
  input  logic [G_NREQ-1:0] en,
  output logic [G_NREQ-1:0] gnt
);

  localparam int unsigned IDX_W = (G_NREQ > 1) ? $clog2(G_NREQ) : 1;

  rr_ptr_t           ptr_q, ptr_d;
  logic [G_NREQ-1:0] pick;
  logic              found;
  int unsigned       idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < G_NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= G_NREQ) idx = idx - G_NREQ;
      if (!found && req[IDX_W'(idx)]) begin
        pick[IDX_W'(idx)] = 1'b1;
        found             = 1'b1;
      end
    end
    gnt   = pick & en;
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < G_NREQ; k++) begin
      if (gnt[k]) ptr_d = rr_ptr_t'((k + 1 == G_NREQ) ? 0 : k + 1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem2p_arbiter.sv
// Shares one blockmem_2p between G_NREQ requesters with tagged, credit-limited read responses.
// Define MEM2P_ARB_HAZARD_EN to stall a read that collides with a same-cycle write.
module mem2p_arbiter
  import mem2p_arb_pkg::*;
#(
  parameter int unsigned G_NREQ      = 2,
  parameter int unsigned G_DATAWIDTH = 32,
  parameter int unsigned G_ADDRWIDTH = 10,
  parameter int unsigned G_WEWIDTH   = 4,
  parameter int unsigned G_IDWIDTH   = (G_NREQ > 1) ? $clog2(G_NREQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [G_NREQ-1:0]             wr_req,
  input  logic [G_NREQ*G_ADDRWIDTH-1:0] wr_addr,
  input  logic [G_NREQ*G_DATAWIDTH-1:0] wr_data,
  input  logic [G_NREQ*G_WEWIDTH-1:0]   wr_be,
  output logic [G_NREQ-1:0]             wr_gnt,
  input  logic [G_NREQ-1:0]             rd_req,
  input  logic [G_NREQ*G_ADDRWIDTH-1:0] rd_addr,
  output logic [G_NREQ-1:0]             rd_gnt,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [G_IDWIDTH-1:0]          rsp_id,
  output logic [G_DATAWIDTH-1:0]        rsp_data,
  output logic                          ena,
  output logic [G_WEWIDTH-1:0]          wea,
  output logic [G_ADDRWIDTH-1:0]        addra,
  output logic [G_DATAWIDTH-1:0]        dina,
  output logic                          enb,
  output logic [G_ADDRWIDTH-1:0]        addrb,
  input  logic [G_DATAWIDTH-1:0]        doutb
);

  logic [G_NREQ-1:0]    wr_en, rd_en, rd_hit;
  logic [G_IDWIDTH-1:0] rd_id;
  logic                 rsp_pop, rd_credit;
  logic [2:0]           credit_use;

  logic                 infl_vld_q, infl_vld_d;
  logic [G_IDWIDTH-1:0] infl_id_q, infl_id_d;
  logic [1:0]           occ_q, occ_d;
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rsp_entry_t           fifo_q [RSP_FIFO_DEPTH];

  assign wr_en = {G_NREQ{resetn}};
  assign rd_en = {G_NREQ{resetn & rd_credit}} & ~rd_hit;

  rr_arbiter #(.G_NREQ(G_NREQ)) u_wr_arb (
    .clk(clk), .resetn(resetn), .req(wr_req), .en(wr_en), .gnt(wr_gnt)
  );

  rr_arbiter #(.G_NREQ(G_NREQ)) u_rd_arb (
    .clk(clk), .resetn(resetn), .req(rd_req), .en(rd_en), .gnt(rd_gnt)
  );

  // Memory port muxes driven by the one-hot grants.
  always_comb begin
    ena   = |wr_gnt;
    wea   = '0;
    addra = '0;
    dina  = '0;
    enb   = |rd_gnt;
    addrb = '0;
    rd_id = '0;
    for (int unsigned k = 0; k < G_NREQ; k++) begin
      if (wr_gnt[k]) begin
        wea   = wr_be[k*G_WEWIDTH +: G_WEWIDTH];
        addra = wr_addr[k*G_ADDRWIDTH +: G_ADDRWIDTH];
        dina  = wr_data[k*G_DATAWIDTH +: G_DATAWIDTH];
      end
      if (rd_gnt[k]) begin
        addrb = rd_addr[k*G_ADDRWIDTH +: G_ADDRWIDTH];
        rd_id = G_IDWIDTH'(k);
      end
    end
  end

`ifdef MEM2P_ARB_HAZARD_EN
  always_comb begin
    rd_hit = '0;
    for (int unsigned k = 0; k < G_NREQ; k++) begin
      rd_hit[k] = ena && (rd_addr[k*G_ADDRWIDTH +: G_ADDRWIDTH] == addra);
    end
  end
`else
  assign rd_hit = '0;
`endif

  // Entries already buffered plus the one in flight, net of this cycle's pop, must leave room.
  assign rsp_pop    = rsp_valid & rsp_ready;
  assign credit_use = 3'(occ_q) + 3'(infl_vld_q) - 3'(rsp_pop);
  assign rd_credit  = credit_use < 3'd2;

  always_comb begin
    infl_vld_d = enb;
    infl_id_d  = enb ? rd_id : infl_id_q;
    wr_ptr_d   = infl_vld_q ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = rsp_pop ? ~rd_ptr_q : rd_ptr_q;
    occ_d      = occ_q + 2'(infl_vld_q) - 2'(rsp_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      infl_vld_q <= 1'b0;
      infl_id_q  <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      infl_vld_q <= infl_vld_d;
      infl_id_q  <= infl_id_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (infl_vld_q) begin
        fifo_q[wr_ptr_q] <= '{id: RSP_ID_W'(infl_id_q), data: RSP_DATA_W'(doutb)};
      end
    end
  end

  assign rsp_valid = (occ_q != 2'd0);
  assign rsp_id    = rsp_valid ? fifo_q[rd_ptr_q].id[G_IDWIDTH-1:0] : '0;
  assign rsp_data  = rsp_valid ? fifo_q[rd_ptr_q].data[G_DATAWIDTH-1:0] : '0;

endmodule
